// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 constant tables (RCON, S-box, inverse S-box) and GF(2^8) helper
package aes_pkg;

  localparam logic [3:0] NR = 4'd10;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational forward AES S-box lookup
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] d
);

  assign d = SBOX[a];

endmodule

// File: rtl/invsbox.sv
// rtl/invsbox.sv - combinational inverse AES S-box lookup for the decipher datapath
module invsbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] d
);

  assign d = INV_SBOX[a];

endmodule

// File: rtl/key_expand.sv
// rtl/key_expand.sv - AES-128 on-the-fly key schedule, one round key per clock
module key_expand
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic [127:0] key,
  output logic [31:0]  wk0,
  output logic [31:0]  wk1,
  output logic [31:0]  wk2,
  output logic [31:0]  wk3
);

  logic [31:0] w0, w1, w2, w3;
  logic [3:0]  rcnt;
  logic [31:0] rot_w3, sub_w3, t;
  logic [31:0] n0, n1, n2, n3;

  assign rot_w3 = {w3[23:0], w3[31:24]};

  aes_sbox u_sbox0 (.a(rot_w3[31:24]), .d(sub_w3[31:24]));
  aes_sbox u_sbox1 (.a(rot_w3[23:16]), .d(sub_w3[23:16]));
  aes_sbox u_sbox2 (.a(rot_w3[15:8]),  .d(sub_w3[15:8]));
  aes_sbox u_sbox3 (.a(rot_w3[7:0]),   .d(sub_w3[7:0]));

  // RCON index is only meaningful while rcnt < NR; the result is unused once idle
  assign t  = sub_w3 ^ {RCON[rcnt], 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w0   <= '0;
      w1   <= '0;
      w2   <= '0;
      w3   <= '0;
      rcnt <= NR;
    end else if (kld) begin
      w0   <= key[127:96];
      w1   <= key[95:64];
      w2   <= key[63:32];
      w3   <= key[31:0];
      rcnt <= 4'd0;
    end else if (rcnt < NR) begin
      w0   <= n0;
      w1   <= n1;
      w2   <= n2;
      w3   <= n3;
      rcnt <= rcnt + 4'd1;
    end
  end

  assign wk0 = w0;
  assign wk1 = w1;
  assign wk2 = w2;
  assign wk3 = w3;

endmodule

// File: tb/tb_key_expand.sv
// tb/tb_key_expand.sv - self-checking bench for key_expand, aes_sbox and invsbox
module tb_key_expand;

  logic         clk;
  logic         rst;
  logic         kld;
  logic [127:0] key;
  logic [31:0]  wk0, wk1, wk2, wk3;
  logic [127:0] wk;

  logic [7:0]   sb_in, sb_out, rt_out, inv_in, inv_out;

  int checks;
  int failures;

  logic [7:0]   sb_ref  [256];
  logic [7:0]   isb_ref [256];
  logic [127:0] rk      [11];

  key_expand dut (
    .clk (clk),
    .rst (rst),
    .kld (kld),
    .key (key),
    .wk0 (wk0),
    .wk1 (wk1),
    .wk2 (wk2),
    .wk3 (wk3)
  );

  aes_sbox u_fwd (.a(sb_in),  .d(sb_out));
  invsbox  u_rt  (.a(sb_out), .d(rt_out));
  invsbox  u_inv (.a(inv_in), .d(inv_out));

  assign wk = {wk0, wk1, wk2, wk3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] d = {b, b} << k;
    return d[15:8];
  endfunction

  // S-box from first principles: multiplicative inverse then affine map
  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (x != 8'h00 && gmul(x, y[7:0]) == 8'h01) inv = y[7:0];
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb_ref[tmp[23:16]], sb_ref[tmp[15:8]], sb_ref[tmp[7:0]], sb_ref[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Edge E0 samples kld; the key bus is scrambled afterwards since it must be ignored
  task automatic load(input logic [127:0] k);
    kld = 1'b1;
    key = k;
    tick();
    kld = 1'b0;
    key = rand128();
  endtask

  task automatic run_schedule(input string tag, input logic [127:0] k, input int hold);
    expand(k);
    load(k);
    check({tag, "_r0"}, wk, rk[0]);
    for (int n = 1; n <= 10; n++) begin
      tick();
      check($sformatf("%s_r%0d", tag, n), wk, rk[n]);
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, "_hold"}, wk, rk[10]);
    end
  endtask

  initial begin
    logic [127:0] k1, k2;
    int           cut;
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    kld      = 1'b0;
    key      = '0;
    sb_in    = 8'h00;
    inv_in   = 8'h00;

    for (int x = 0; x < 256; x++) sb_ref[x] = sbox_model(x[7:0]);
    for (int x = 0; x < 256; x++) isb_ref[sb_ref[x]] = x[7:0];

    // Reset holds outputs at zero even with kld active
    for (int i = 0; i < 3; i++) begin
      kld = 1'b1;
      key = rand128();
      tick();
      check("reset_zero", wk, '0);
    end
    kld = 1'b0;
    #2 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_reset_idle", wk, '0);
    end

    k1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    expand(k1);
    load(k1);
    check("fips_r0", wk, k1);
    tick();
    check("fips_r1", wk, 128'ha0fafe1788542cb123a339392a6c7605);
    for (int n = 2; n <= 10; n++) tick();
    check("fips_r10", wk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    for (int h = 0; h < 5; h++) begin
      tick();
      check("fips_hold", wk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    end
    run_schedule("fips_model", k1, 1);

    k2 = 128'h000102030405060708090a0b0c0d0e0f;
    load(k2);
    for (int n = 1; n <= 10; n++) tick();
    check("seq_r10", wk, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Consecutive kld edges: last sampled key wins
    kld = 1'b1;
    key = k2;
    tick();
    key = k1;
    tick();
    kld = 1'b0;
    check("kld_back_to_back", wk, k1);

    // Reload at E0+4 with the second key
    load(k1);
    for (int n = 1; n <= 3; n++) tick();
    expand(k2);
    load(k2);
    check("reload_key", wk, k2);
    for (int n = 1; n <= 9; n++) tick();
    check("reload_r9", wk, rk[9]);
    tick();
    check("reload_r10", wk, rk[10]);

    // Asynchronous reset between edges at E0+5
    load(k1);
    for (int n = 1; n <= 5; n++) tick();
    #2 rst = 1'b0;
    #1 check("async_reset", wk, '0);
    #1 rst = 1'b1;
    tick();
    check("async_reset_idle", wk, '0);

    for (int i = 0; i < 6; i++) run_schedule("rand", rand128(), $urandom_range(0, 2));

    for (int i = 0; i < 6; i++) begin
      k1  = rand128();
      k2  = rand128();
      cut = $urandom_range(1, 10);
      load(k1);
      for (int n = 1; n < cut; n++) tick();
      run_schedule("rand_reload", k2, 0);
    end

    sb_in  = 8'h00; inv_in = 8'h00; #1;
    check("sbox_00", {120'h0, sb_out}, 128'h63);
    check("inv_00", {120'h0, inv_out}, 128'h52);
    sb_in  = 8'h53; inv_in = 8'h63; #1;
    check("sbox_53", {120'h0, sb_out}, 128'hed);
    check("inv_63", {120'h0, inv_out}, 128'h00);
    inv_in = 8'h7c; #1;
    check("inv_7c", {120'h0, inv_out}, 128'h01);
    inv_in = 8'hff; #1;
    check("inv_ff", {120'h0, inv_out}, 128'h7d);

    for (int x = 0; x < 256; x++) begin
      sb_in  = x[7:0];
      inv_in = x[7:0];
      #1;
      check($sformatf("sbox_%02h", x), {120'h0, sb_out}, {120'h0, sb_ref[x]});
      check($sformatf("inv_%02h", x), {120'h0, inv_out}, {120'h0, isb_ref[x]});
      check($sformatf("roundtrip_%02h", x), {120'h0, rt_out}, {120'h0, x[7:0]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
